// File: rtl/reg_wb_arbiter_pkg.sv
// Shared widths, arbitration constants and FSM state type for the
// register-file writeback arbiter.
package reg_wb_arbiter_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned NUM_REGS   = 1 << ADDR_W;
    localparam int unsigned STARVE_MAX = 3;

    typedef enum logic {
        PRI_LD  = 1'b0,
        PRI_ALU = 1'b1
    } arb_state_t;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Writeback bus: ALU and load handshakes, decode hazard query and the
// register-file write port.
interface reg_wb_arbiter_if;
    import reg_wb_arbiter_pkg::*;

    logic                alu_valid;
    logic [ADDR_W-1:0]   alu_addr;
    logic [DATA_W-1:0]   alu_data;
    logic                alu_ready;
    logic                ld_valid;
    logic [ADDR_W-1:0]   ld_addr;
    logic [DATA_W-1:0]   ld_data;
    logic                ld_ready;
    logic                issue_en;
    logic [ADDR_W-1:0]   issue_rd;
    logic [ADDR_W-1:0]   chk_rn;
    logic [ADDR_W-1:0]   chk_rm;
    logic                hazard;
    logic                rf_w_en;
    logic [ADDR_W-1:0]   rf_wr_addr;
    logic [DATA_W-1:0]   rf_wr_data;
    logic [NUM_REGS-1:0] busy_mask;

    modport master (
        output alu_valid, alu_addr, alu_data,
        input  alu_ready,
        output ld_valid, ld_addr, ld_data,
        input  ld_ready,
        output issue_en, issue_rd, chk_rn, chk_rm,
        input  hazard, rf_w_en, rf_wr_addr, rf_wr_data, busy_mask
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        output alu_ready,
        input  ld_valid, ld_addr, ld_data,
        output ld_ready,
        input  issue_en, issue_rd, chk_rn, chk_rm,
        output hazard, rf_w_en, rf_wr_addr, rf_wr_data, busy_mask
    );

endinterface

// File: rtl/reg_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue,
// cleared on writeback (set wins on the same index), three lookups.
module reg_scoreboard
    import reg_wb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [ADDR_W-1:0]   set_addr,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_addr,
    input  logic [ADDR_W-1:0]   rn_addr,
    input  logic [ADDR_W-1:0]   rm_addr,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rn_busy,
    output logic                rm_busy,
    output logic                rd_busy,
    output logic [NUM_REGS-1:0] mask
);

    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en) set_vec[set_addr] = 1'b1;
        if (clr_en) clr_vec[clr_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) mask <= '0;
        else     mask <= (mask & ~clr_vec) | set_vec;
    end

    assign rn_busy = mask[rn_addr];
    assign rm_busy = mask[rm_addr];
    assign rd_busy = mask[rd_addr];

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: load-priority with an ALU anti-starvation escape,
// registered register-file write port and pending-write scoreboard.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = reg_wb_arbiter_pkg::STARVE_MAX
)
(
    input  logic             clk,
    input  logic             rst,
    reg_wb_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t       state, state_next;
    logic [CNT_W-1:0] starve_cnt, cnt_next;
    logic             grant_alu, grant_ld, alu_lost;
    logic             rn_busy, rm_busy, rd_busy;

    always_comb begin
        grant_alu  = 1'b0;
        grant_ld   = 1'b0;
        state_next = state;
        cnt_next   = starve_cnt;
        if (!rst) begin
            if (bus.alu_valid && bus.ld_valid) begin
                if (state == PRI_ALU) grant_alu = 1'b1;
                else                  grant_ld  = 1'b1;
            end else if (bus.alu_valid) begin
                grant_alu = 1'b1;
            end else if (bus.ld_valid) begin
                grant_ld = 1'b1;
            end
        end
        alu_lost = bus.alu_valid && grant_ld;
        if (grant_alu) begin
            cnt_next = '0;
            if (state == PRI_ALU) state_next = PRI_LD;
        end else if (alu_lost) begin
            if (state == PRI_LD && starve_cnt == CNT_W'(STARVE_MAX - 1))
                state_next = PRI_ALU;
            if (starve_cnt != CNT_W'(STARVE_MAX))
                cnt_next = starve_cnt + CNT_W'(1);
        end
    end

    assign bus.alu_ready = grant_alu;
    assign bus.ld_ready  = grant_ld;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= PRI_LD;
            starve_cnt     <= '0;
            bus.rf_w_en    <= 1'b0;
            bus.rf_wr_addr <= '0;
            bus.rf_wr_data <= '0;
        end else begin
            state       <= state_next;
            starve_cnt  <= cnt_next;
            bus.rf_w_en <= grant_alu | grant_ld;
            if (grant_alu) begin
                bus.rf_wr_addr <= bus.alu_addr;
                bus.rf_wr_data <= bus.alu_data;
            end else if (grant_ld) begin
                bus.rf_wr_addr <= bus.ld_addr;
                bus.rf_wr_data <= bus.ld_data;
            end
        end
    end

    reg_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (bus.issue_en),
        .set_addr (bus.issue_rd),
        .clr_en   (bus.rf_w_en),
        .clr_addr (bus.rf_wr_addr),
        .rn_addr  (bus.chk_rn),
        .rm_addr  (bus.chk_rm),
        .rd_addr  (bus.issue_rd),
        .rn_busy  (rn_busy),
        .rm_busy  (rm_busy),
        .rd_busy  (rd_busy),
        .mask     (bus.busy_mask)
    );

    assign bus.hazard = rn_busy | rm_busy | rd_busy;

    // Re-issuing a destination in its own retire cycle is legal (set wins).
    assert property (@(posedge clk) disable iff (rst)
        !(bus.issue_en && bus.hazard &&
          !(bus.rf_w_en && bus.issue_rd == bus.rf_wr_addr && !rn_busy && !rm_busy)));

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed and random checks of reg_wb_arbiter against a priority/scoreboard
// reference model built from the arbitration rules.
module tb_reg_wb_arbiter;
    import reg_wb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_wb_arbiter_if bus ();

    reg_wb_arbiter #(.STARVE_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] m_busy;
    int          m_losses;
    logic        m_rf_en;
    logic [3:0]  m_rf_addr;
    logic [31:0] m_rf_data;
    logic        g_alu, g_ld, obs_alu, obs_ld;
    int          writes_r2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = '0; m_losses = 0; m_rf_en = 1'b0; m_rf_addr = '0; m_rf_data = '0;
    endtask

    // One clock: check everything at the negedge, advance the model, then step past the edge.
    task automatic cycle();
        logic exp_alu, exp_ld, exp_haz;
        @(negedge clk);
        exp_alu = 1'b0;
        exp_ld  = 1'b0;
        if (!rst) begin
            if (bus.alu_valid && bus.ld_valid) begin
                if (m_losses >= 3) exp_alu = 1'b1;
                else               exp_ld  = 1'b1;
            end else if (bus.alu_valid) exp_alu = 1'b1;
            else if (bus.ld_valid)      exp_ld  = 1'b1;
        end
        exp_haz = m_busy[bus.chk_rn] | m_busy[bus.chk_rm] | m_busy[bus.issue_rd];
        obs_alu = bus.alu_ready;
        obs_ld  = bus.ld_ready;
        chk("alu_ready",  32'(obs_alu),        32'(exp_alu));
        chk("ld_ready",   32'(obs_ld),         32'(exp_ld));
        chk("hazard",     32'(bus.hazard),     32'(exp_haz));
        chk("rf_w_en",    32'(bus.rf_w_en),    32'(m_rf_en));
        chk("rf_wr_addr", 32'(bus.rf_wr_addr), 32'(m_rf_addr));
        chk("rf_wr_data", bus.rf_wr_data,      m_rf_data);
        chk("busy_mask",  32'(bus.busy_mask),  32'(m_busy));
        if (bus.rf_w_en === 1'b1 && bus.rf_wr_addr === 4'd2) writes_r2++;
        g_alu = exp_alu;
        g_ld  = exp_ld;
        if (rst) begin
            model_reset();
        end else begin
            if (m_rf_en)      m_busy[m_rf_addr]    = 1'b0;
            if (bus.issue_en) m_busy[bus.issue_rd] = 1'b1;
            m_rf_en = exp_alu | exp_ld;
            if (exp_alu) begin
                m_rf_addr = bus.alu_addr; m_rf_data = bus.alu_data;
            end else if (exp_ld) begin
                m_rf_addr = bus.ld_addr;  m_rf_data = bus.ld_data;
            end
            if (exp_alu)                         m_losses = 0;
            else if (bus.alu_valid && exp_ld)    m_losses++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] t5_list [4];
        int         idx;
        logic [3:0] rd;

        bus.alu_valid = 1'b1; bus.alu_addr = '0; bus.alu_data = '0;
        bus.ld_valid  = 1'b1; bus.ld_addr  = '0; bus.ld_data  = '0;
        bus.issue_en  = 1'b0; bus.issue_rd = '0;
        bus.chk_rn    = '0;   bus.chk_rm   = '0;
        model_reset();
        writes_r2 = 0;

        // Reset held with both requests pending
        rst = 1'b1;
        cycle();
        cycle();
        chk("t1_busy_mask", 32'(bus.busy_mask), 32'h0);
        rst = 1'b0;
        bus.alu_valid = 1'b0;
        bus.ld_valid  = 1'b0;

        // Single ALU write to R3
        bus.issue_en = 1'b1; bus.issue_rd = 4'd3;
        cycle();
        bus.issue_en = 1'b0; bus.issue_rd = 4'd0;
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd3; bus.alu_data = 32'hDEADBEEF;
        bus.chk_rn = 4'd3;
        cycle();
        chk("t2_alu_ready", 32'(obs_alu), 32'd1);
        bus.alu_valid = 1'b0;
        chk("t2_rf_w_en", 32'(bus.rf_w_en), 32'd1);
        chk("t2_rf_addr", 32'(bus.rf_wr_addr), 32'd3);
        chk("t2_rf_data", bus.rf_wr_data, 32'hDEADBEEF);
        chk("t2_hazard_during_write", 32'(bus.hazard), 32'd1);
        cycle();
        chk("t2_busy3_cleared", 32'(bus.busy_mask[3]), 32'd0);
        chk("t2_hazard_after", 32'(bus.hazard), 32'd0);
        bus.chk_rn = 4'd0;

        // Contention: ld R1..R5 against a held ALU write to R6
        bus.ld_valid  = 1'b1; bus.ld_addr  = 4'd1; bus.ld_data  = 32'h1000_0001;
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd6; bus.alu_data = 32'h2000_0006;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk($sformatf("t3_ld_win_%0d", k),  32'(obs_ld),  (k == 3) ? 32'd0 : 32'd1);
            chk($sformatf("t3_alu_win_%0d", k), 32'(obs_alu), (k == 3) ? 32'd1 : 32'd0);
            if (obs_alu) bus.alu_valid = 1'b0;
            if (obs_ld) begin
                bus.ld_addr = bus.ld_addr + 4'd1;
                bus.ld_data = 32'h1000_0000 | 32'(bus.ld_addr);
            end
        end
        cycle();
        bus.ld_valid = 1'b0;
        cycle();

        // Re-issue R7 in the cycle R7 is being written
        bus.issue_en = 1'b1; bus.issue_rd = 4'd7;
        cycle();
        bus.issue_en = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd7; bus.alu_data = 32'h0000_0077;
        cycle();
        bus.alu_valid = 1'b0;
        bus.issue_en = 1'b1; bus.issue_rd = 4'd7;
        cycle();
        bus.issue_en = 1'b0; bus.issue_rd = 4'd0;
        chk("t4_busy7_kept", 32'(bus.busy_mask[7]), 32'd1);

        // Load to R2 held while the ALU owns priority
        t5_list = '{4'd9, 4'd10, 4'd11, 4'd2};
        idx = 0;
        writes_r2 = 0;
        bus.ld_valid  = 1'b1; bus.ld_addr  = t5_list[0]; bus.ld_data = 32'h3000_0009;
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd12;      bus.alu_data = 32'h4000_000C;
        for (int k = 0; k < 6 && bus.ld_valid; k++) begin
            cycle();
            if (k == 3) chk("t5_ld_held_loses", 32'(obs_ld), 32'd0);
            if (obs_alu) bus.alu_valid = 1'b0;
            if (obs_ld) begin
                if (bus.ld_addr == 4'd2) begin
                    bus.ld_valid = 1'b0;
                    chk("t5_accept_addr", 32'(bus.rf_wr_addr), 32'd2);
                    chk("t5_accept_data", bus.rf_wr_data, 32'h5555_AAAA);
                end else begin
                    idx++;
                    bus.ld_addr = t5_list[idx];
                    bus.ld_data = (t5_list[idx] == 4'd2) ? 32'h5555_AAAA
                                                         : 32'h3000_0000 | 32'(t5_list[idx]);
                end
            end
        end
        chk("t5_ld_done", 32'(bus.ld_valid), 32'd0);
        cycle();
        cycle();
        chk("t5_r2_writes", 32'(writes_r2), 32'd1);

        // Reset in the middle of a write with R4..R7 pending
        for (int r = 4; r < 7; r++) begin
            bus.issue_en = 1'b1; bus.issue_rd = 4'(r);
            cycle();
        end
        bus.issue_en = 1'b0; bus.issue_rd = 4'd0;
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd8; bus.alu_data = 32'h0000_0088;
        cycle();
        bus.alu_valid = 1'b0;
        chk("t6_pre_rf_w_en", 32'(bus.rf_w_en), 32'd1);
        chk("t6_pre_busy", 32'(bus.busy_mask), 32'h00F0);
        rst = 1'b1;
        cycle();
        chk("t6_rf_w_en", 32'(bus.rf_w_en), 32'd0);
        chk("t6_rf_addr", 32'(bus.rf_wr_addr), 32'd0);
        chk("t6_rf_data", bus.rf_wr_data, 32'd0);
        chk("t6_busy", 32'(bus.busy_mask), 32'd0);
        chk("t6_hazard", 32'(bus.hazard), 32'd0);
        rst = 1'b0;

        // Random traffic with held requests and hazard-free issue
        for (int n = 0; n < 400; n++) begin
            bus.chk_rn = 4'($urandom_range(15));
            bus.chk_rm = 4'($urandom_range(15));
            rd = 4'($urandom_range(15));
            bus.issue_rd = rd;
            bus.issue_en = (!rst && !m_busy[rd] && !m_busy[bus.chk_rn] && !m_busy[bus.chk_rm]
                            && $urandom_range(2) == 0);
            cycle();
            rst = ($urandom_range(99) == 0);
            if (rst) begin
                bus.alu_valid = 1'b0;
                bus.ld_valid  = 1'b0;
            end else begin
                if (!bus.alu_valid || g_alu) begin
                    bus.alu_valid = ($urandom_range(9) < 6);
                    bus.alu_addr  = 4'($urandom_range(15));
                    bus.alu_data  = $urandom;
                end
                if (!bus.ld_valid || g_ld) begin
                    bus.ld_valid = ($urandom_range(9) < 6);
                    bus.ld_addr  = 4'($urandom_range(15));
                    bus.ld_data  = $urandom;
                end
            end
        end
        rst = 1'b0;
        bus.issue_en = 1'b0;
        bus.alu_valid = 1'b0;
        bus.ld_valid = 1'b0;
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
